// File: rtl/overlay_compositor_if.sv
// overlay_compositor_if
//   Pixel-stream bundle between the beam timing / emblem generator side
//   (master) and the overlay compositor output stage (slave).
//   Inputs to the compositor:
//     x, y          beam column / row
//     active        visible-area flag
//     hsync, vsync  raw sync pins (active low)
//     bg_rgb        background colour for this pixel
//     emblem_draw   emblem generator covers this pixel
//     emblem_rgb    emblem colour
//     show          level request: 1 = emblem visible, 0 = hidden
//   Outputs from the compositor:
//     rgb_out               registered pixel colour
//     hsync_out, vsync_out  sync pins delayed one clock
//     wipe_row              current exclusive wipe bound
//     busy, shown           animation status
interface overlay_compositor_if;
  logic [9:0] x;
  logic [9:0] y;
  logic       active;
  logic       hsync;
  logic       vsync;
  logic [5:0] bg_rgb;
  logic       emblem_draw;
  logic [5:0] emblem_rgb;
  logic       show;

  logic [5:0] rgb_out;
  logic       hsync_out;
  logic       vsync_out;
  logic [9:0] wipe_row;
  logic       busy;
  logic       shown;

  modport master (
    output x, y, active, hsync, vsync, bg_rgb, emblem_draw, emblem_rgb, show,
    input  rgb_out, hsync_out, vsync_out, wipe_row, busy, shown
  );

  modport slave (
    input  x, y, active, hsync, vsync, bg_rgb, emblem_draw, emblem_rgb, show,
    output rgb_out, hsync_out, vsync_out, wipe_row, busy, shown
  );
endinterface

// File: rtl/overlay_compositor.sv
// overlay_compositor
//   Final VGA output stage. Gates the emblem generator's draw/colour with a
//   frame-synchronous vertical wipe, composites it over the background,
//   registers the 6-bit colour and delays the sync pins by the same single
//   clock so the output stays pixel-aligned. A four-state animation FSM,
//   advanced only on a once-per-frame tick in vertical blanking, moves the
//   wipe bound up (reveal) or down (hide) under the level `show` request.
// Ports:
//   clk  pixel clock
//   rst  synchronous active-high reset
//   pix  overlay_compositor_if.slave (beam position, syncs, colours, show
//        request in; composited colour, delayed syncs, wipe bound and
//        busy/shown status out)
module overlay_compositor #(
  parameter int WIPE_Y0    = 144,
  parameter int WIPE_Y1    = 320,
  parameter int WIPE_STEP  = 4,
  parameter int TICK_LINE  = 480,
  parameter bit SYNC_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  overlay_compositor_if.slave   pix
);

  // 11-bit forms for the step arithmetic so the up-step can never wrap.
  localparam logic [10:0] Y0_W   = 11'(WIPE_Y0);
  localparam logic [10:0] Y1_W   = 11'(WIPE_Y1);
  localparam logic [10:0] STEP_W = 11'(WIPE_STEP);
  localparam logic [9:0]  Y0_N   = 10'(WIPE_Y0);
  localparam logic [9:0]  Y1_N   = 10'(WIPE_Y1);
  localparam logic [9:0]  STEP_N = 10'(WIPE_STEP);
  localparam logic [9:0]  TICK_N = 10'(TICK_LINE);

  typedef enum logic [1:0] {
    HIDDEN = 2'd0,
    REVEAL = 2'd1,
    SHOWN  = 2'd2,
    HIDE   = 2'd3
  } state_t;

  state_t     state_q, state_d;
  logic [9:0] wipe_row_q, wipe_row_d;
  logic [5:0] rgb_q, rgb_d;
  logic       hsync_q, hsync_d;
  logic       vsync_q, vsync_d;
  logic       busy_q, busy_d;
  logic       shown_q, shown_d;

  logic       tick;
  logic [10:0] up_sum;
  logic [9:0] wipe_up;
  logic [9:0] wipe_dn;
  logic       vis;

  // Tick lands in vertical blanking, so the wipe bound never moves mid-frame.
  assign tick = (pix.x == 10'd0) && (pix.y == TICK_N);

  // Saturating steps. The down-step compares before subtracting, so the
  // difference is only formed when it cannot go below WIPE_Y0.
  always_comb begin
    up_sum  = {1'b0, wipe_row_q} + STEP_W;
    wipe_up = (up_sum >= Y1_W) ? Y1_N : up_sum[9:0];
    wipe_dn = ({1'b0, wipe_row_q} <= (Y0_W + STEP_W)) ? Y0_N
                                                      : (wipe_row_q - STEP_N);
  end

  // Animation next-state. `show` is only looked at on the tick; a reversal
  // steps in the new direction on the same tick it is seen.
  always_comb begin
    state_d    = state_q;
    wipe_row_d = wipe_row_q;
    if (tick) begin
      case (state_q)
        HIDDEN: begin
          if (pix.show) begin
            state_d    = REVEAL;
            wipe_row_d = wipe_up;
          end
        end
        REVEAL: begin
          if (!pix.show) begin
            state_d    = HIDE;
            wipe_row_d = wipe_dn;
          end else begin
            wipe_row_d = wipe_up;
            if (wipe_up == Y1_N) begin
              state_d = SHOWN;
            end
          end
        end
        SHOWN: begin
          if (!pix.show) begin
            state_d    = HIDE;
            wipe_row_d = wipe_dn;
          end
        end
        HIDE: begin
          if (pix.show) begin
            state_d    = REVEAL;
            wipe_row_d = wipe_up;
          end else begin
            wipe_row_d = wipe_dn;
            if (wipe_dn == Y0_N) begin
              state_d = HIDDEN;
            end
          end
        end
        default: begin
          state_d    = HIDDEN;
          wipe_row_d = Y0_N;
        end
      endcase
    end
  end

  // Status flags are registered from the next state so they always equal a
  // direct decode of the state register.
  always_comb begin
    busy_d  = (state_d == REVEAL) || (state_d == HIDE);
    shown_d = (state_d == SHOWN);
  end

  // Pixel path: compare against the registered wipe bound (pre-update value).
  always_comb begin
    vis = pix.emblem_draw && (pix.y < wipe_row_q);
    if (!pix.active) begin
      rgb_d = 6'd0;
    end else if (vis) begin
      rgb_d = pix.emblem_rgb;
    end else begin
      rgb_d = pix.bg_rgb;
    end
    hsync_d = pix.hsync;
    vsync_d = pix.vsync;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= HIDDEN;
      wipe_row_q <= Y0_N;
      rgb_q      <= 6'd0;
      hsync_q    <= SYNC_RESET;
      vsync_q    <= SYNC_RESET;
      busy_q     <= 1'b0;
      shown_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      wipe_row_q <= wipe_row_d;
      rgb_q      <= rgb_d;
      hsync_q    <= hsync_d;
      vsync_q    <= vsync_d;
      busy_q     <= busy_d;
      shown_q    <= shown_d;
    end
  end

  assign pix.rgb_out   = rgb_q;
  assign pix.hsync_out = hsync_q;
  assign pix.vsync_out = vsync_q;
  assign pix.wipe_row  = wipe_row_q;
  assign pix.busy      = busy_q;
  assign pix.shown     = shown_q;

endmodule

// File: tb/tb_overlay_compositor.sv
// Bench for overlay_compositor: two instances (step 4 and step 5) share one
// stimulus stream; a frame-level animation model predicts every output.
module tb_overlay_compositor;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] x, y;
  logic       active, hsync, vsync, emblem_draw, show;
  logic [5:0] bg_rgb, emblem_rgb;

  always #5 clk = ~clk;

  overlay_compositor_if bus0();
  overlay_compositor_if bus1();

  assign bus0.x = x;           assign bus1.x = x;
  assign bus0.y = y;           assign bus1.y = y;
  assign bus0.active = active; assign bus1.active = active;
  assign bus0.hsync = hsync;   assign bus1.hsync = hsync;
  assign bus0.vsync = vsync;   assign bus1.vsync = vsync;
  assign bus0.bg_rgb = bg_rgb; assign bus1.bg_rgb = bg_rgb;
  assign bus0.emblem_draw = emblem_draw; assign bus1.emblem_draw = emblem_draw;
  assign bus0.emblem_rgb = emblem_rgb;   assign bus1.emblem_rgb = emblem_rgb;
  assign bus0.show = show;     assign bus1.show = show;

  overlay_compositor #(.WIPE_Y0(144), .WIPE_Y1(320), .WIPE_STEP(4),
                       .TICK_LINE(480), .SYNC_RESET(1'b1))
    dut0 (.clk(clk), .rst(rst), .pix(bus0));

  overlay_compositor #(.WIPE_Y0(144), .WIPE_Y1(320), .WIPE_STEP(5),
                       .TICK_LINE(480), .SYNC_RESET(1'b1))
    dut1 (.clk(clk), .rst(rst), .pix(bus1));

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Animation seen as: a target direction (last sampled show), a wipe
  // height, and whether the wipe has come to rest at the target end.
  int   m_wipe [2];
  bit   m_dir  [2];
  bit   m_rest [2];
  int   m_step [2] = '{4, 5};
  int   e_rgb  [2];
  bit   e_hs   [2];
  bit   e_vs   [2];

  function automatic int step_to(int w, bit up, int st);
    if (up) return (w + st > 320) ? 320 : w + st;
    else    return (w - st < 144) ? 144 : w - st;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        e_rgb[i] = 0; e_hs[i] = 1'b1; e_vs[i] = 1'b1;
        m_wipe[i] = 144; m_dir[i] = 1'b0; m_rest[i] = 1'b1;
      end else begin
        if (!active) e_rgb[i] = 0;
        else if (emblem_draw && (int'(y) < m_wipe[i])) e_rgb[i] = int'(emblem_rgb);
        else e_rgb[i] = int'(bg_rgb);
        e_hs[i] = hsync;
        e_vs[i] = vsync;
        if (x == 0 && y == 480) begin
          if (show != m_dir[i]) begin
            m_dir[i]  = show;
            m_rest[i] = 1'b0;
            m_wipe[i] = step_to(m_wipe[i], show, m_step[i]);
          end else if (!m_rest[i]) begin
            m_wipe[i] = step_to(m_wipe[i], show, m_step[i]);
            m_rest[i] = (m_wipe[i] == (show ? 320 : 144));
          end
        end
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("i0 rgb",   int'(bus0.rgb_out),   e_rgb[0]);
      chk("i0 hs",    int'(bus0.hsync_out), int'(e_hs[0]));
      chk("i0 vs",    int'(bus0.vsync_out), int'(e_vs[0]));
      chk("i0 wipe",  int'(bus0.wipe_row),  m_wipe[0]);
      chk("i0 busy",  int'(bus0.busy),      int'(!m_rest[0]));
      chk("i0 shown", int'(bus0.shown),     int'(m_rest[0] && m_dir[0]));
      chk("i1 rgb",   int'(bus1.rgb_out),   e_rgb[1]);
      chk("i1 hs",    int'(bus1.hsync_out), int'(e_hs[1]));
      chk("i1 vs",    int'(bus1.vsync_out), int'(e_vs[1]));
      chk("i1 wipe",  int'(bus1.wipe_row),  m_wipe[1]);
      chk("i1 busy",  int'(bus1.busy),      int'(!m_rest[1]));
      chk("i1 shown", int'(bus1.shown),     int'(m_rest[1] && m_dir[1]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_pix();
    x = 10'(1 + $urandom_range(798));
    y = 10'($urandom_range(524));
    active = 1'($urandom);
    hsync = 1'($urandom);
    vsync = 1'($urandom);
    bg_rgb = 6'($urandom);
    emblem_rgb = 6'($urandom);
    emblem_draw = 1'($urandom);
  endtask

  task automatic tick_cycle(input bit s);
    rand_pix();
    x = 10'd0;
    y = 10'd480;
    show = s;
    cycle();
  endtask

  task automatic frame(input bit s);
    show = s;
    repeat (3) begin rand_pix(); cycle(); end
    tick_cycle(s);
  endtask

  task automatic pixel(input int py, input bit drw, input int emb, input int bg);
    x = 10'd100; y = 10'(py); active = 1'b1; hsync = 1'b1; vsync = 1'b1;
    emblem_draw = drw; emblem_rgb = 6'(emb); bg_rgb = 6'(bg);
    cycle();
  endtask

  initial begin
    // Reset held three clocks with random inputs.
    rst = 1'b1; show = 1'b0; rand_pix();
    cycle();
    chk_en = 1'b1;
    repeat (2) begin rand_pix(); show = 1'($urandom); cycle(); end
    chk("rst rgb",   int'(bus0.rgb_out), 0);
    chk("rst hs",    int'(bus0.hsync_out), 1);
    chk("rst vs",    int'(bus0.vsync_out), 1);
    chk("rst wipe",  int'(bus0.wipe_row), 144);
    chk("rst busy",  int'(bus0.busy), 0);
    chk("rst shown", int'(bus0.shown), 0);
    rst = 1'b0; show = 1'b0;
    pixel(200, 1'b1, 'h36, 'h2A);
    chk("hidden bg", int'(bus0.rgb_out), 'h2A);

    // Latency and blanking with a walking sync pattern.
    for (int i = 0; i < 16; i++) begin
      x = 10'(i + 1); y = 10'd250;
      hsync = (i % 3) != 0; vsync = (i % 5) != 1; active = i[0];
      bg_rgb = 6'h15; emblem_draw = 1'b0; emblem_rgb = 6'h3F;
      cycle();
      chk("lat hs", int'(bus0.hsync_out), int'(hsync));
      chk("lat vs", int'(bus0.vsync_out), int'(vsync));
      chk("lat rgb", int'(bus0.rgb_out), active ? 'h15 : 0);
    end

    // Full reveal.
    for (int k = 1; k <= 44; k++) begin
      frame(1'b1);
      chk("rev wipe", int'(bus0.wipe_row), 144 + 4 * k);
      chk("rev busy", int'(bus0.busy), (k < 44) ? 1 : 0);
      chk("rev shown", int'(bus0.shown), (k == 44) ? 1 : 0);
      if (k == 35) chk("s5 rev 35", int'(bus1.wipe_row), 319);
      if (k == 36) begin
        chk("s5 rev clamp", int'(bus1.wipe_row), 320);
        chk("s5 shown", int'(bus1.shown), 1);
      end
    end
    pixel(319, 1'b1, 'h36, 'h09);
    chk("shown emb", int'(bus0.rgb_out), 'h36);

    // Hide down to 200, then partial gating.
    repeat (30) frame(1'b0);
    chk("hide 200", int'(bus0.wipe_row), 200);
    pixel(199, 1'b1, 'h36, 'h15);
    chk("gate 199", int'(bus0.rgb_out), 'h36);
    pixel(200, 1'b1, 'h36, 'h15);
    chk("gate 200", int'(bus0.rgb_out), 'h15);

    for (int j = 0; j < 14; j++) begin
      frame(1'b0);
      if (j == 4) chk("s5 hide 145", int'(bus1.wipe_row), 145);
      if (j == 5) begin
        chk("s5 hide clamp", int'(bus1.wipe_row), 144);
        chk("s5 hidden", int'(bus1.busy), 0);
      end
    end
    chk("hidden wipe", int'(bus0.wipe_row), 144);
    chk("hidden busy", int'(bus0.busy), 0);

    // Reversal.
    repeat (10) frame(1'b1);
    chk("rv 184", int'(bus0.wipe_row), 184);
    frame(1'b0);
    chk("rv 180", int'(bus0.wipe_row), 180);
    chk("rv busy", int'(bus0.busy), 1);
    repeat (10) frame(1'b0);
    chk("rv 144", int'(bus0.wipe_row), 144);
    chk("rv idle", int'(bus0.busy), 0);
    // show pulse between ticks is ignored
    show = 1'b1;
    repeat (3) begin rand_pix(); cycle(); end
    show = 1'b0;
    tick_cycle(1'b0);
    chk("pulse wipe", int'(bus0.wipe_row), 144);
    chk("pulse busy", int'(bus0.busy), 0);

    // Reset mid-reveal, asserted on a tick cycle.
    repeat (24) frame(1'b1);
    chk("mid 240", int'(bus0.wipe_row), 240);
    rst = 1'b1;
    tick_cycle(1'b1);
    chk("mid rst wipe", int'(bus0.wipe_row), 144);
    chk("mid rst busy", int'(bus0.busy), 0);
    chk("mid rst shown", int'(bus0.shown), 0);
    rst = 1'b0;

    // Randomized run, checked by the model every cycle.
    for (int n = 0; n < 5000; n++) begin
      rand_pix();
      if ($urandom_range(5) == 0) begin x = 10'd0; y = 10'd480; end
      else if ($urandom_range(1) == 0) y = 10'(140 + $urandom_range(190));
      if ($urandom_range(299) == 0) show = ~show;
      if ($urandom_range(39) == 0) show = 1'($urandom); // between-tick glitches
      rst = ($urandom_range(1499) == 0);
      cycle();
    end
    rst = 1'b0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/overlay_compositor.md
# overlay_compositor

Output stage directly downstream of the emblem overlay generator. Each clock it takes the generator's combinational `draw`/`rgb` for the current beam position, gates the emblem with a frame-synchronous vertical wipe, and composites it over the background colour. It registers the final 6-bit colour and delays the sync pins by the same amount, so the VGA output stays pixel-aligned. A small FSM driven by a once-per-frame tick animates the emblem in and out under a level `show` request.

## Interface
Parameters:
- `WIPE_Y0`, 144: first emblem line; wipe lower bound.
- `WIPE_Y1`, 320: one past the last emblem line; wipe upper bound.
- `WIPE_STEP`, 4: lines added or removed per frame tick; must be nonzero.
- `TICK_LINE`, 480: `y` value at which the frame tick fires.
- `SYNC_RESET`, 1: reset and idle value of the delayed sync outputs (active-low sync).

Ports:
- `clk`, in, 1: pixel clock.
- `rst`, in, 1: synchronous, active-high reset.
- `x`, in, 10: beam column from the timing generator.
- `y`, in, 10: beam row from the timing generator.
- `active`, in, 1: visible-area flag.
- `hsync`, in, 1: raw horizontal sync.
- `vsync`, in, 1: raw vertical sync.
- `bg_rgb`, in, 6: background colour for the current pixel.
- `emblem_draw`, in, 1: emblem generator covers this pixel.
- `emblem_rgb`, in, 6: emblem generator colour.
- `show`, in, 1: level request; 1 = emblem visible, 0 = hidden.
- `rgb_out`, out, 6: registered pixel colour.
- `hsync_out`, out, 1: `hsync` delayed one clock.
- `vsync_out`, out, 1: `vsync` delayed one clock.
- `wipe_row`, out, 10: current exclusive wipe bound.
- `busy`, out, 1: FSM is in REVEAL or HIDE.
- `shown`, out, 1: FSM is in SHOWN.

## Operation
- **Frame tick:** `tick = (x == 0) && (y == TICK_LINE)`. It fires in vertical blanking, so `wipe_row` never changes mid-frame.
- **FSM states:** HIDDEN, REVEAL, SHOWN, HIDE. All transitions happen only on a tick.
  - HIDDEN: `show=1` → REVEAL, and `wipe_row` advances one step on the same tick.
  - REVEAL: `show=0` → HIDE, with `wipe_row` stepping down from its current value. Otherwise `wipe_row` steps up. Enter SHOWN on the tick where the saturated result equals `WIPE_Y1`.
  - SHOWN: `show=0` → HIDE, with one step down on that tick.
  - HIDE: `show=1` → REVEAL, with one step up. Otherwise step down. Enter HIDDEN on the tick where the result equals `WIPE_Y0`.
- **Step arithmetic:** done in 11 bits. Up: `min(wipe_row + WIPE_STEP, WIPE_Y1)`. Down: `max(wipe_row − WIPE_STEP, WIPE_Y0)`. No wrap is possible.
- **`show` sampling:** `show` is sampled only on the tick. Toggles between ticks are ignored.
- **Pixel rule:** `vis = emblem_draw && (y < wipe_row)`. `wipe_row` is in register form, i.e. the value before any update on this clock.
- **Next colour:**
  - `active=0` → 0.
  - Otherwise `vis` → `emblem_rgb`.
  - Otherwise `bg_rgb`.
- **Output flags:** `busy` and `shown` decode the state register directly.

## Timing
- Latency is exactly 1 clock. `rgb_out`, `hsync_out` and `vsync_out` at cycle n+1 reflect the inputs at cycle n.
- Reset (synchronous, checked before any other logic), values on the following edge:
  - `rgb_out` = 0.
  - `hsync_out` = `vsync_out` = `SYNC_RESET`.
  - state = HIDDEN, `wipe_row` = `WIPE_Y0`.
  - `busy` = 0, `shown` = 0.
- Reset mid-wipe aborts the animation. Reset asserted on a tick cycle overrides the tick.
- State and `wipe_row` update on the clock edge ending the tick cycle. The first frame affected is the frame following that tick.
- Full reveal or full hide with the defaults takes 176/4 = 44 ticks. `shown` rises at the edge ending the 44th tick after the request was sampled.
- A direction reversal takes effect on the tick where it is sampled; there is no extra dead frame.

## Test plan
- **Reset:** hold `rst` for 3 clocks with random inputs → `rgb_out`=0, syncs=1, `wipe_row`=144, `busy`=`shown`=0. After release, in HIDDEN, an emblem pixel at y=200 outputs `bg_rgb`.
- **Latency and blanking:** drive `hsync`/`vsync` with a walking pattern, alternating `active`, `bg_rgb`=6'h15, `emblem_draw`=0 → syncs out are a 1-clock-delayed copy. `rgb_out` is 6'h15 one clock after `active`=1 and 0 one clock after `active`=0.
- **Full reveal:** `show`=1 held, step the frame ticks → `wipe_row` reads 148, 152, … 320. `busy`=1 throughout. `shown`=1 after tick 44. In SHOWN, `emblem_draw`=1 at y=319 outputs `emblem_rgb`=6'h36.
- **Partial gating:** with `wipe_row`=200, `emblem_draw`=1 → `rgb_out`=`emblem_rgb` at y=199 and `bg_rgb` at y=200.
- **Reversal:** `show`=1 for 10 ticks (`wipe_row`=184), then `show`=0 → next tick gives 180 in HIDE. After 10 more ticks it is 144 and the state is HIDDEN. A `show` pulse that does not overlap a tick leaves the state unchanged.
- **Saturation and reset mid-operation:** `WIPE_STEP`=5 → the last reveal step clamps to 320 and the last hide step clamps to 144. Asserting `rst` during REVEAL with `wipe_row`=240 → HIDDEN and 144 on the next edge.
